ebus_dev_responder: RTL and testbench

EBUS_DEV_RESPONDER -- requirements
Module: ebus_dev_responder

---
 rtl/ebus_pkg.sv | 28 ++
 rtl/ebus_pi_req.sv | 32 +++
 rtl/ebus_dev_responder.sv | 183 ++++++++++++++++++
 tb/tb_ebus_dev_responder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ebus_pkg.sv
// Shared EBUS responder types: function codes, FSM states and the 36-bit word.
// Vector bit [35-n] carries EBUS bit n, so EBUS bits 33:35 map to [2:0].
package ebus_pkg;

  typedef logic [35:0] ebus_word_t;

  typedef enum logic [2:0] {
    FUNC_CONO     = 3'd0,
    FUNC_CONI     = 3'd1,
    FUNC_DATAO    = 3'd2,
    FUNC_DATAI    = 3'd3,
    FUNC_PI_SERVE = 3'd4
  } ebus_func_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_XFER    = 2'd2,
    ST_RELEASE = 2'd3
  } ebus_state_t;

  localparam ebus_word_t PIA_FIELD_MASK = 36'o000000_000007;

  function automatic logic is_write_func(input logic [2:0] func);
    return (func == FUNC_CONO) || (func == FUNC_DATAO);
  endfunction

endpackage

// File: rtl/ebus_pi_req.sv
// PI request mapping: the registered device request is steered onto the
// request line of the assigned PI level; level 0 means no level assigned.
module ebus_pi_req
  import ebus_pkg::*;
(
  input  logic       clk_ebus_h,
  input  logic       mr_reset_h,
  input  logic [2:0] pia,
  input  logic       int_req_h,
  output logic [6:0] pi_h
);

  logic       int_req_q;
  logic [2:0] line_sel;

  always_ff @(posedge clk_ebus_h) begin
    if (mr_reset_h) begin
      int_req_q <= 1'b0;
    end else begin
      int_req_q <= int_req_h;
    end
  end

  always_comb begin
    pi_h     = '0;
    line_sel = pia - 3'd1;
    if (pia != 3'd0) begin
      pi_h[line_sel] = int_req_q;
    end
  end

endmodule

// File: rtl/ebus_dev_responder.sv
// EBUS device responder: answers CONO/CONI/DATAO/DATAI/PI-serve for one
// controller select. Optional EBUS_PARITY_EN adds odd data parity.
module ebus_dev_responder
  import ebus_pkg::*;
#(
  parameter logic [6:0] DEV_CS   = 7'o040,
  parameter logic [3:0] XFER_DLY = 4'd2
) (
  input  logic        clk_ebus_h,
  input  logic        mr_reset_h,
  input  logic [6:0]  ebus_cs_h,
  input  logic [2:0]  ebus_func_h,
  input  logic        ebus_demand_h,
  input  logic [2:0]  ebus_pi_lvl_h,
  input  logic [35:0] ebus_d_in_h,
  output logic        ebus_xfer_h,
  output logic [35:0] ebus_d_out_h,
  output logic        ebus_d_oe_h,
  output logic [6:0]  ebus_pi_h,
  input  logic [35:0] dev_coni_h,
  input  logic [35:0] dev_datai_h,
  input  logic        dev_int_req_h,
  input  logic [35:0] dev_int_vec_h,
  output logic [35:0] dev_wdata_h,
  output logic        dev_cono_h,
  output logic        dev_datao_h,
  output logic        dev_datai_rd_h,
  output logic        dev_int_ack_h
`ifdef EBUS_PARITY_EN
  ,
  input  logic        ebus_par_in_h,
  output logic        ebus_par_out_h,
  output logic        dev_par_err_h
`endif
);

  ebus_state_t state;
  ebus_func_t  func_q;
  ebus_word_t  data_q;
  logic [3:0]  dly_cnt;
  logic [2:0]  pia;
  logic        demand_q;
  logic        accept;
  logic        wr_ok;

`ifdef EBUS_PARITY_EN
  logic        par_bad_q;
  logic        rx_par_bad;

  assign rx_par_bad = is_write_func(ebus_func_h) && !(^{ebus_d_in_h, ebus_par_in_h});
  assign wr_ok      = !par_bad_q;
`else
  assign wr_ok      = 1'b1;
`endif

  always_comb begin
    accept = 1'b0;
    if (ebus_demand_h && !demand_q && (ebus_cs_h == DEV_CS)) begin
      case (ebus_func_h)
        FUNC_CONO, FUNC_CONI, FUNC_DATAO, FUNC_DATAI: accept = 1'b1;
        FUNC_PI_SERVE: accept = (pia != 3'd0) && (ebus_pi_lvl_h == pia) && dev_int_req_h;
        default:       accept = 1'b0;
      endcase
    end
  end

  // demand_q tracks the bus even during reset so a demand held across
  // reset release is not mistaken for a fresh edge.
  always_ff @(posedge clk_ebus_h) begin
    demand_q <= ebus_demand_h;
    if (mr_reset_h) begin
      state          <= ST_IDLE;
      func_q         <= FUNC_CONO;
      data_q         <= '0;
      dly_cnt        <= '0;
      pia            <= '0;
      dev_wdata_h    <= '0;
      dev_cono_h     <= 1'b0;
      dev_datao_h    <= 1'b0;
      dev_datai_rd_h <= 1'b0;
      dev_int_ack_h  <= 1'b0;
`ifdef EBUS_PARITY_EN
      par_bad_q      <= 1'b0;
      dev_par_err_h  <= 1'b0;
`endif
    end else begin
      dev_cono_h     <= 1'b0;
      dev_datao_h    <= 1'b0;
      dev_datai_rd_h <= 1'b0;
      dev_int_ack_h  <= 1'b0;
`ifdef EBUS_PARITY_EN
      dev_par_err_h  <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state   <= ST_WAIT;
            dly_cnt <= XFER_DLY;
            func_q  <= ebus_func_t'(ebus_func_h);
            data_q  <= ebus_d_in_h;
`ifdef EBUS_PARITY_EN
            par_bad_q <= rx_par_bad;
`endif
          end
        end
        ST_WAIT: begin
          if (!ebus_demand_h) begin
            state <= ST_IDLE;
          end else if (dly_cnt == 4'd0) begin
            state <= ST_XFER;
            case (func_q)
              FUNC_CONO: begin
                if (wr_ok) begin
                  dev_cono_h  <= 1'b1;
                  dev_wdata_h <= data_q;
                  pia         <= data_q[2:0];
                end
              end
              FUNC_DATAO: begin
                if (wr_ok) begin
                  dev_datao_h <= 1'b1;
                  dev_wdata_h <= data_q;
                end
              end
              FUNC_DATAI:    dev_datai_rd_h <= 1'b1;
              FUNC_PI_SERVE: dev_int_ack_h  <= 1'b1;
              default: ;
            endcase
`ifdef EBUS_PARITY_EN
            dev_par_err_h <= par_bad_q;
`endif
          end else begin
            dly_cnt <= dly_cnt - 4'd1;
          end
        end
        ST_XFER: begin
          if (!ebus_demand_h) begin
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Read data is sampled live for the whole XFER window.
  always_comb begin
    ebus_xfer_h  = (state == ST_XFER);
    ebus_d_oe_h  = 1'b0;
    ebus_d_out_h = '0;
    if (state == ST_XFER) begin
      case (func_q)
        FUNC_CONI: begin
          ebus_d_oe_h  = 1'b1;
          ebus_d_out_h = (dev_coni_h & ~PIA_FIELD_MASK) | {33'd0, pia};
        end
        FUNC_DATAI: begin
          ebus_d_oe_h  = 1'b1;
          ebus_d_out_h = dev_datai_h;
        end
        FUNC_PI_SERVE: begin
          ebus_d_oe_h  = 1'b1;
          ebus_d_out_h = dev_int_vec_h;
        end
        default: ;
      endcase
    end
  end

`ifdef EBUS_PARITY_EN
  assign ebus_par_out_h = ebus_d_oe_h ? ~(^ebus_d_out_h) : 1'b0;
`endif

  ebus_pi_req u_pi_req (
    .clk_ebus_h (clk_ebus_h),
    .mr_reset_h (mr_reset_h),
    .pia        (pia),
    .int_req_h  (dev_int_req_h),
    .pi_h       (ebus_pi_h)
  );

endmodule

// File: tb/tb_ebus_dev_responder.sv
// Bench for ebus_dev_responder: table of single transactions plus directed
// sequences for demand drop, release re-demand, zero delay, reset and parity.
module tb_ebus_dev_responder;

  localparam logic [3:0] DLY = 4'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  cs;
  logic [2:0]  func, lvl;
  logic        demand, demand2, int_req;
  logic [35:0] din, coni, datai, vecw;

  logic        xfer, oe, cono, datao, drd, ack;
  logic [35:0] dout, wdata;
  logic [6:0]  pi;
  logic        xfer2, oe2, cono2, datao2, drd2, ack2;
  logic [35:0] dout2, wdata2;
  logic [6:0]  pi2;
`ifdef EBUS_PARITY_EN
  logic        par_in, par_out, par_err, par_out2, par_err2, par_bad_inject;
  int          n_perr;
`endif

  int total = 0;
  int bad   = 0;
  int n_cono, n_datao, n_drd, n_ack, n_xfer;

  always #5 clk = ~clk;

  ebus_dev_responder #(.DEV_CS(7'o040), .XFER_DLY(DLY)) dut (
    .clk_ebus_h(clk), .mr_reset_h(rst), .ebus_cs_h(cs), .ebus_func_h(func),
    .ebus_demand_h(demand), .ebus_pi_lvl_h(lvl), .ebus_d_in_h(din),
    .ebus_xfer_h(xfer), .ebus_d_out_h(dout), .ebus_d_oe_h(oe), .ebus_pi_h(pi),
    .dev_coni_h(coni), .dev_datai_h(datai), .dev_int_req_h(int_req),
    .dev_int_vec_h(vecw), .dev_wdata_h(wdata), .dev_cono_h(cono),
    .dev_datao_h(datao), .dev_datai_rd_h(drd), .dev_int_ack_h(ack)
`ifdef EBUS_PARITY_EN
    , .ebus_par_in_h(par_in), .ebus_par_out_h(par_out), .dev_par_err_h(par_err)
`endif
  );

  ebus_dev_responder #(.DEV_CS(7'o040), .XFER_DLY(4'd0)) dut_dly0 (
    .clk_ebus_h(clk), .mr_reset_h(rst), .ebus_cs_h(cs), .ebus_func_h(func),
    .ebus_demand_h(demand2), .ebus_pi_lvl_h(lvl), .ebus_d_in_h(din),
    .ebus_xfer_h(xfer2), .ebus_d_out_h(dout2), .ebus_d_oe_h(oe2), .ebus_pi_h(pi2),
    .dev_coni_h(coni), .dev_datai_h(datai), .dev_int_req_h(int_req),
    .dev_int_vec_h(vecw), .dev_wdata_h(wdata2), .dev_cono_h(cono2),
    .dev_datao_h(datao2), .dev_datai_rd_h(drd2), .dev_int_ack_h(ack2)
`ifdef EBUS_PARITY_EN
    , .ebus_par_in_h(par_in), .ebus_par_out_h(par_out2), .dev_par_err_h(par_err2)
`endif
  );

  typedef struct {
    logic [2:0]  func;
    logic [6:0]  cs;
    logic [35:0] din;
    logic [2:0]  lvl;
    logic        int_req;
    logic [35:0] coni;
    logic [35:0] datai;
    logic [35:0] vec;
    logic        resp;
    logic [35:0] exp_dout;
    logic        exp_oe;
    logic [3:0]  exp_strb;   // {cono, datao, datai_rd, int_ack}
    logic [35:0] exp_wdata;
    logic [6:0]  exp_pi;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic [2:0] f, input logic [6:0] c, input logic [35:0] d,
                              input logic [2:0] l, input logic ir, input logic [35:0] cn,
                              input logic [35:0] dt, input logic [35:0] vv, input logic r,
                              input logic [35:0] ed, input logic eo, input logic [3:0] es,
                              input logic [35:0] ew, input logic [6:0] ep);
    vec_t v;
    v.func = f; v.cs = c; v.din = d; v.lvl = l; v.int_req = ir; v.coni = cn;
    v.datai = dt; v.vec = vv; v.resp = r; v.exp_dout = ed; v.exp_oe = eo;
    v.exp_strb = es; v.exp_wdata = ew; v.exp_pi = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_cnt();
    n_cono = 0; n_datao = 0; n_drd = 0; n_ack = 0; n_xfer = 0;
`ifdef EBUS_PARITY_EN
    n_perr = 0;
`endif
  endtask

  task automatic step();
    @(negedge clk);
    if (cono)  n_cono++;
    if (datao) n_datao++;
    if (drd)   n_drd++;
    if (ack)   n_ack++;
    if (xfer)  n_xfer++;
`ifdef EBUS_PARITY_EN
    if (par_err) n_perr++;
`endif
  endtask

  function automatic logic [15:0] strb_counts();
    return {n_cono[3:0], n_datao[3:0], n_drd[3:0], n_ack[3:0]};
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    lat = 0;
    @(negedge clk);
    cs = v.cs; func = v.func; din = v.din; lvl = v.lvl; int_req = v.int_req;
    coni = v.coni; datai = v.datai; vecw = v.vec;
`ifdef EBUS_PARITY_EN
    par_in = ~(^v.din);
`endif
    demand = 1'b1;
    clr_cnt();
    for (int i = 1; i <= 12; i++) begin
      step();
      if (xfer) begin
        lat = i;
        break;
      end
    end
    if (v.resp) begin
      chk($sformatf("v%0d_latency", idx), lat, DLY + 2);
      chk($sformatf("v%0d_dout", idx), dout, v.exp_dout);
      chk($sformatf("v%0d_oe", idx), oe, v.exp_oe);
      step();
      chk($sformatf("v%0d_xfer_hold", idx), xfer, 1'b1);
      chk($sformatf("v%0d_dout_hold", idx), dout, v.exp_dout);
      demand = 1'b0;
      step();
      chk($sformatf("v%0d_release", idx), {xfer, oe, dout}, 38'd0);
      step();
    end else begin
      chk($sformatf("v%0d_ignored", idx), lat, 0);
      demand = 1'b0;
      step();
    end
    chk($sformatf("v%0d_strobes", idx), strb_counts(),
        {3'd0, v.exp_strb[3], 3'd0, v.exp_strb[2], 3'd0, v.exp_strb[1], 3'd0, v.exp_strb[0]});
    chk($sformatf("v%0d_wdata", idx), wdata, v.exp_wdata);
    chk($sformatf("v%0d_pi", idx), pi, v.exp_pi);
  endtask

  task automatic start_txn(input logic [2:0] f, input logic [35:0] d, output int lat);
    @(negedge clk);
    cs = 7'o040; func = f; din = d;
`ifdef EBUS_PARITY_EN
    par_in = ~(^d) ^ par_bad_inject;
`endif
    demand = 1'b1;
    clr_cnt();
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (xfer) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic end_txn();
    demand = 1'b0;
    step();
    step();
  endtask

  initial begin
    int lat;
    tbl[0]  = mk(3'd0, 7'o040, 36'o000000_000005, 3'd0, 1'b1, '0, '0, '0,
                 1'b1, '0, 1'b0, 4'b1000, 36'o000000_000005, 7'b0010000);
    tbl[1]  = mk(3'd1, 7'o040, '0, 3'd0, 1'b1, 36'o123456_701230, '0, '0,
                 1'b1, 36'o123456_701235, 1'b1, 4'b0000, 36'o000000_000005, 7'b0010000);
    tbl[2]  = mk(3'd2, 7'o040, 36'o777000_123456, 3'd0, 1'b1, '0, '0, '0,
                 1'b1, '0, 1'b0, 4'b0100, 36'o777000_123456, 7'b0010000);
    tbl[3]  = mk(3'd3, 7'o040, '0, 3'd0, 1'b1, '0, 36'o252525_252525, '0,
                 1'b1, 36'o252525_252525, 1'b1, 4'b0010, 36'o777000_123456, 7'b0010000);
    tbl[4]  = mk(3'd4, 7'o040, '0, 3'd5, 1'b1, '0, '0, 36'o000000_000142,
                 1'b1, 36'o000000_000142, 1'b1, 4'b0001, 36'o777000_123456, 7'b0010000);
    tbl[5]  = mk(3'd4, 7'o040, '0, 3'd3, 1'b1, '0, '0, 36'o000000_000142,
                 1'b0, '0, 1'b0, 4'b0000, 36'o777000_123456, 7'b0010000);
    tbl[6]  = mk(3'd4, 7'o040, '0, 3'd5, 1'b0, '0, '0, 36'o000000_000142,
                 1'b0, '0, 1'b0, 4'b0000, 36'o777000_123456, 7'b0000000);
    tbl[7]  = mk(3'd0, 7'o041, 36'o000000_000001, 3'd0, 1'b1, '0, '0, '0,
                 1'b0, '0, 1'b0, 4'b0000, 36'o777000_123456, 7'b0010000);
    tbl[8]  = mk(3'd5, 7'o040, 36'o000000_000001, 3'd5, 1'b1, '0, '0, '0,
                 1'b0, '0, 1'b0, 4'b0000, 36'o777000_123456, 7'b0010000);
    tbl[9]  = mk(3'd0, 7'o040, 36'o000000_000000, 3'd0, 1'b1, '0, '0, '0,
                 1'b1, '0, 1'b0, 4'b1000, 36'o000000_000000, 7'b0000000);
    tbl[10] = mk(3'd4, 7'o040, '0, 3'd0, 1'b1, '0, '0, 36'o000000_000142,
                 1'b0, '0, 1'b0, 4'b0000, 36'o000000_000000, 7'b0000000);
    tbl[11] = mk(3'd0, 7'o040, 36'o400000_000003, 3'd0, 1'b1, '0, '0, '0,
                 1'b1, '0, 1'b0, 4'b1000, 36'o400000_000003, 7'b0000100);
    tbl[12] = mk(3'd1, 7'o040, '0, 3'd0, 1'b1, 36'o777777_777777, '0, '0,
                 1'b1, 36'o777777_777773, 1'b1, 4'b0000, 36'o400000_000003, 7'b0000100);

    rst = 1'b1; demand = 1'b0; demand2 = 1'b0; cs = '0; func = '0; lvl = '0;
    din = '0; coni = '0; datai = '0; vecw = '0; int_req = 1'b1;
`ifdef EBUS_PARITY_EN
    par_in = 1'b0; par_bad_inject = 1'b0;
`endif
    clr_cnt();
    repeat (3) step();
    chk("in_reset_outputs", {xfer, oe, dout, pi}, 45'd0);
    rst = 1'b0;
    step();
    chk("post_reset_outputs", {xfer, oe, dout, pi, wdata}, 81'd0);
    chk("post_reset_strobes", strb_counts(), 16'd0);

    for (int i = 0; i < 13; i++) run_vec(i, tbl[i]);

    // Demand withdrawn during the first WAIT cycle: nothing may happen.
    @(negedge clk);
    cs = 7'o040; func = 3'd0; din = 36'o000000_000007; demand = 1'b1;
`ifdef EBUS_PARITY_EN
    par_in = ~(^din);
`endif
    clr_cnt();
    step();
    demand = 1'b0;
    repeat (6) step();
    chk("wait_drop_no_xfer", n_xfer, 0);
    chk("wait_drop_strobes", strb_counts(), 16'd0);
    chk("wait_drop_wdata", wdata, 36'o400000_000003);
    chk("wait_drop_pi", pi, 7'b0000100);

    // Demand re-raised during RELEASE is not a new transaction.
    datai = 36'o000000_000444;
    start_txn(3'd3, '0, lat);
    chk("rel_first_latency", lat, DLY + 2);
    demand = 1'b0;
    step();
    demand = 1'b1;
    clr_cnt();
    repeat (8) step();
    chk("rel_redemand_no_xfer", n_xfer, 0);
    chk("rel_redemand_strobes", strb_counts(), 16'd0);
    end_txn();

    // Zero-delay instance: xfer one cycle after acceptance.
    @(negedge clk);
    cs = 7'o040; func = 3'd3; datai = 36'o111111_222222; demand2 = 1'b1;
    @(negedge clk);
    chk("dly0_not_yet", xfer2, 1'b0);
    @(negedge clk);
    chk("dly0_xfer", xfer2, 1'b1);
    chk("dly0_dout", dout2, 36'o111111_222222);
    chk("dly0_strobe", drd2, 1'b1);
    @(negedge clk);
    chk("dly0_strobe_single", drd2, 1'b0);
    demand2 = 1'b0;
    @(negedge clk);
    chk("dly0_release", {xfer2, oe2, dout2}, 38'd0);
    @(negedge clk);

`ifdef EBUS_PARITY_EN
    par_bad_inject = 1'b1;
    start_txn(3'd2, 36'o000000_000001, lat);
    chk("par_bad_latency", lat, DLY + 2);
    par_bad_inject = 1'b0;
    step();
    end_txn();
    chk("par_bad_err", n_perr, 1);
    chk("par_bad_no_datao", n_datao, 0);
    chk("par_bad_wdata", wdata, 36'o400000_000003);
    start_txn(3'd2, 36'o000000_000003, lat);
    end_txn();
    chk("par_good_err", n_perr, 0);
    chk("par_good_datao", n_datao, 1);
    chk("par_good_wdata", wdata, 36'o000000_000003);
    datai = 36'o000000_000003;
    start_txn(3'd3, '0, lat);
    chk("par_out_datai", par_out, 1'b1);
    end_txn();
`endif

    // Reset while in XFER with demand held across release.
    datai = 36'o525252_525252;
    start_txn(3'd3, '0, lat);
    chk("rst_xfer_latency", lat, DLY + 2);
    rst = 1'b1;
    step();
    chk("rst_xfer_outputs", {xfer, oe, dout, pi}, 45'd0);
    chk("rst_xfer_wdata", wdata, 36'd0);
    rst = 1'b0;
    clr_cnt();
    repeat (8) step();
    chk("rst_held_demand_no_xfer", n_xfer, 0);
    chk("rst_held_demand_strobes", strb_counts(), 16'd0);
    chk("rst_pi_cleared", pi, 7'd0);
    end_txn();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
